// File: rtl/gp_block_serializer.sv
// Buffers 128-bit grasshopper cipher blocks in a small FIFO and streams them out one byte at a time.
// Define GP_SER_BYTE_SWAP_EN to emit bytes LSB first; the default build emits them MSB first.
module gp_block_serializer #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data_i,
  input  logic         valid_i,
  output logic         ack_o,
  output logic         full_o,
  output logic [7:0]   byte_o,
  output logic         byte_valid_o,
  input  logic         byte_ready_i,
  output logic         last_o,
  output logic         busy_o,
  output logic         overflow_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [127:0]   r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic [127:0]   r_shreg;
  logic [3:0]     r_idx;
  logic           r_ack;
  logic           r_overflow;

  logic           w_fifo_ne;
  logic           w_full;
  logic           w_xfer;
  logic           w_last_xfer;
  logic           w_pop;
  logic           w_push;
  logic [7:0]     w_byte;
  logic [127:0]   w_shreg_adv;

  assign w_fifo_ne   = (r_count != '0);
  assign w_full      = (r_count == LP_FULL);
  assign w_xfer      = (r_state == ST_SHIFT) && byte_ready_i;
  assign w_last_xfer = w_xfer && (r_idx == 4'd15);
  // A block leaves the FIFO when the shifter is idle or is finishing its last byte.
  assign w_pop       = w_fifo_ne && ((r_state == ST_IDLE) || w_last_xfer);
  assign w_push      = valid_i && (!w_full || w_pop);

`ifdef GP_SER_BYTE_SWAP_EN
  assign w_byte      = r_shreg[7:0];
  assign w_shreg_adv = {8'h00, r_shreg[127:8]};
`else
  assign w_byte      = r_shreg[127:120];
  assign w_shreg_adv = {r_shreg[119:0], 8'h00};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_fifo_ne) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last_xfer && !w_fifo_ne) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_valid_o = 1'b0;
    last_o       = 1'b0;
    byte_o       = 8'h00;
    if (r_state == ST_SHIFT) begin
      byte_valid_o = 1'b1;
      last_o       = (r_idx == 4'd15);
      byte_o       = w_byte;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_idx      <= 4'd0;
      r_ack      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_ack <= w_push;
      if (valid_i && !w_push) r_overflow <= 1'b1;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop)       r_idx <= 4'd0;
      else if (w_xfer) r_idx <= r_idx + 4'd1;
    end
  end

  // Block storage and shifter contents carry no reset; byte_o is masked while idle.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= data_i;
    if (w_pop)       r_shreg <= r_mem[r_rptr];
    else if (w_xfer) r_shreg <= w_shreg_adv;
  end

  assign ack_o      = r_ack;
  assign overflow_o = r_overflow;
  assign full_o     = w_full;
  assign busy_o     = w_fifo_ne || (r_state == ST_SHIFT);

endmodule

// File: tb/tb_gp_block_serializer.sv
// Directed bench for gp_block_serializer: single block, overflow burst, backpressure,
// full FIFO with same-cycle pop, and reset mid-block. Follows GP_SER_BYTE_SWAP_EN if defined.
module tb_gp_block_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] data_i;
  logic         valid_i;
  logic         ack_o;
  logic         full_o;
  logic [7:0]   byte_o;
  logic         byte_valid_o;
  logic         byte_ready_i;
  logic         last_o;
  logic         busy_o;
  logic         overflow_o;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [127:0] BLK_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BLK_C = 128'h0123456789abcdeffedcba9876543210;
`ifdef GP_SER_BYTE_SWAP_EN
  localparam logic [7:0] C_B0 = 8'h10;
  localparam logic [7:0] C_B1 = 8'h32;
`else
  localparam logic [7:0] C_B0 = 8'h01;
  localparam logic [7:0] C_B1 = 8'h23;
`endif

  gp_block_serializer #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ack_o        (ack_o),
    .full_o       (full_o),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .byte_ready_i (byte_ready_i),
    .last_o       (last_o),
    .busy_o       (busy_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    valid_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Byte k of BLK_A in emission order: 00,11,..,ff MSB first or ff,ee,..,00 swapped.
  function automatic logic [7:0] a_byte(input int k);
`ifdef GP_SER_BYTE_SWAP_EN
    return 8'(8'h11 * (15 - k));
`else
    return 8'(8'h11 * k);
`endif
  endfunction

  initial begin
    int  nb;
    int  gaps;
    bit  started;
    bit  busy_seen;
    bit  found;

    rst = 1'b0;
    data_i = '0;
    valid_i = 1'b0;
    byte_ready_i = 1'b1;
    tick();
    tick();
    chk("rst_byte",     128'(byte_o), 128'(0));
    chk("rst_bvalid",   128'(byte_valid_o), 128'(0));
    chk("rst_last",     128'(last_o), 128'(0));
    chk("rst_ack",      128'(ack_o), 128'(0));
    chk("rst_full",     128'(full_o), 128'(0));
    chk("rst_busy",     128'(busy_o), 128'(0));
    chk("rst_overflow", 128'(overflow_o), 128'(0));
    rst = 1'b1;
    tick();

    // Single block, one-cycle latency.
    data_i = BLK_A;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("single_ack",     128'(ack_o), 128'(1));
    chk("single_bv_lat",  128'(byte_valid_o), 128'(0));
    chk("single_busy",    128'(busy_o), 128'(1));
    tick();
    chk("single_ack_off", 128'(ack_o), 128'(0));
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("single_byte%0d", k), 128'(byte_o), 128'(a_byte(k)));
      chk($sformatf("single_last%0d", k), 128'(last_o), 128'(k == 15));
      chk($sformatf("single_bv%0d", k),   128'(byte_valid_o), 128'(1));
      tick();
    end
    chk("single_bv_end",   128'(byte_valid_o), 128'(0));
    chk("single_busy_end", 128'(busy_o), 128'(0));
    chk("single_ovf",      128'(overflow_o), 128'(0));

    // Back-to-back: 11 blocks, first 5 accepted, 80 bytes with no gaps.
    do_reset();
    nb = 0; gaps = 0; started = 1'b0; busy_seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      valid_i = (c < 11);
      data_i = {16{8'(c + 1)}};
      tick();
      chk($sformatf("b2b_ack_c%0d", c), 128'(ack_o), 128'(c < 5));
      if (byte_valid_o) begin
        started = 1'b1;
        if (nb < 80) begin
          chk($sformatf("b2b_byte%0d", nb), 128'(byte_o), 128'(8'(nb / 16 + 1)));
          chk($sformatf("b2b_last%0d", nb), 128'(last_o), 128'((nb % 16) == 15));
        end
        nb++;
      end else if (started && nb < 80) begin
        gaps++;
      end else if (nb == 80 && !busy_seen) begin
        chk("b2b_busy_fall", 128'(busy_o), 128'(0));
        busy_seen = 1'b1;
      end
    end
    valid_i = 1'b0;
    chk("b2b_nbytes",   128'(nb), 128'(80));
    chk("b2b_gaps",     128'(gaps), 128'(0));
    chk("b2b_busy_seen", 128'(busy_seen), 128'(1));
    chk("b2b_overflow", 128'(overflow_o), 128'(1));

    // Backpressure at index 7.
    do_reset();
    chk("bp_ovf_cleared", 128'(overflow_o), 128'(0));
    data_i = BLK_A;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("bp_pre%0d", k), 128'(byte_o), 128'(a_byte(k)));
      tick();
    end
    chk("bp_at7", 128'(byte_o), 128'(a_byte(7)));
    byte_ready_i = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk($sformatf("bp_hold%0d", s),  128'(byte_o), 128'(a_byte(7)));
      chk($sformatf("bp_bv%0d", s),    128'(byte_valid_o), 128'(1));
      chk($sformatf("bp_last%0d", s),  128'(last_o), 128'(0));
    end
    byte_ready_i = 1'b1;
    for (int k = 8; k < 16; k++) begin
      tick();
      chk($sformatf("bp_post%0d", k), 128'(byte_o), 128'(a_byte(k)));
      chk($sformatf("bp_plast%0d", k), 128'(last_o), 128'(k == 15));
    end
    tick();
    chk("bp_idle", 128'(byte_valid_o), 128'(0));

    // Full FIFO accepts a block on the cycle byte 15 leaves.
    do_reset();
    for (int j = 1; j <= 5; j++) begin
      valid_i = 1'b1;
      data_i = {16{8'(j)}};
      tick();
    end
    valid_i = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 40; w++) begin
      if (last_o) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("fp_wait_last", 128'(found), 128'(1));
    chk("fp_full",      128'(full_o), 128'(1));
    chk("fp_blk1",      128'(byte_o), 128'(8'h01));
    valid_i = 1'b1;
    data_i = {16{8'h06}};
    tick();
    valid_i = 1'b0;
    chk("fp_ack",      128'(ack_o), 128'(1));
    chk("fp_ovf",      128'(overflow_o), 128'(0));
    chk("fp_full_kept", 128'(full_o), 128'(1));
    chk("fp_no_bubble", 128'(byte_valid_o), 128'(1));
    nb = 0;
    for (int w = 0; w < 200; w++) begin
      if (byte_valid_o) begin
        if (nb < 80)
          chk($sformatf("fp_byte%0d", nb), 128'(byte_o), 128'(8'(2 + nb / 16)));
        nb++;
      end
      if (!busy_o) break;
      tick();
    end
    chk("fp_nbytes", 128'(nb), 128'(80));
    chk("fp_ovf_end", 128'(overflow_o), 128'(0));

    // Reset mid-block at index 9.
    do_reset();
    data_i = BLK_A;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    for (int k = 0; k < 9; k++) tick();
    chk("mr_at9", 128'(byte_o), 128'(a_byte(9)));
    rst = 1'b0;
    #1;
    chk("mr_byte",   128'(byte_o), 128'(0));
    chk("mr_bv",     128'(byte_valid_o), 128'(0));
    chk("mr_last",   128'(last_o), 128'(0));
    chk("mr_ack",    128'(ack_o), 128'(0));
    chk("mr_full",   128'(full_o), 128'(0));
    chk("mr_busy",   128'(busy_o), 128'(0));
    chk("mr_ovf",    128'(overflow_o), 128'(0));
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mr_idle_after", 128'(byte_valid_o), 128'(0));
    data_i = BLK_C;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("mr_new_ack", 128'(ack_o), 128'(1));
    tick();
    chk("mr_new_bv",  128'(byte_valid_o), 128'(1));
    chk("mr_new_b0",  128'(byte_o), 128'(C_B0));
    tick();
    chk("mr_new_b1",  128'(byte_o), 128'(C_B1));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
